tx_frame_scheduler: RTL



---
 rtl/tx_frame_scheduler.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/tx_frame_scheduler.sv
// Round-robin scheduler sharing one serial Transmitter among four requesters.
// Optional macro HIPRI0_EN gives port 0 fixed priority over the rotation.
module tx_frame_scheduler #(
  parameter int DATA_W  = 16,
  parameter int LEN_W   = 4,
  parameter int GAP_CYC = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clkEn,
  input  logic [3:0]            Req,
  input  logic [4*LEN_W-1:0]    Len,
  input  logic [4*DATA_W-1:0]   DataIn,
  input  logic                  Done,
  output logic                  SerIn,
  output logic [3:0]            Grant,
  output logic [3:0]            Ack,
  output logic                  Err,
  output logic                  Busy
);

  localparam int CNT_W = $clog2(TIMEOUT + DATA_W + GAP_CYC + 1);
  localparam int LI_W  = $clog2(LEN_W);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_PORT, S_LENF, S_DATA, S_WAIT_DONE, S_GAP
  } state_e;

  state_e              r_state, w_state_nxt;
  logic [1:0]          r_ptr, w_ptr_nxt;
  logic [1:0]          r_id, w_id_nxt;
  logic [LEN_W-1:0]    r_len, w_len_nxt;
  logic [DATA_W-1:0]   r_data, w_data_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic                r_ser, w_ser_nxt;
  logic [3:0]          r_grant, w_grant_nxt;
  logic [3:0]          r_ack, w_ack_nxt;
  logic                r_err, w_err_nxt;
  logic                r_busy, w_busy_nxt;

  logic [1:0]          w_sel;
  logic                w_req_hit;
  logic                w_hipri;
  logic [LI_W-1:0]     w_len_idx;
  logic [LEN_W-1:0]    w_dat_idx;

`ifdef HIPRI0_EN
  assign w_hipri = Req[0];
`else
  assign w_hipri = 1'b0;
`endif

  // Bit currently on the line is r_cnt; the next one sent is r_cnt-1.
  assign w_len_idx = r_cnt[LI_W-1:0] - LI_W'(1);
  assign w_dat_idx = r_cnt[LEN_W-1:0] - LEN_W'(1);

  always_comb begin
    w_sel     = r_ptr;
    w_req_hit = 1'b0;
    // Scan downward so the port closest to r_ptr is the one left selected.
    for (int k = 3; k >= 0; k--) begin
      if (Req[r_ptr + 2'(k)]) begin
        w_sel     = r_ptr + 2'(k);
        w_req_hit = 1'b1;
      end
    end
    if (w_hipri) w_sel = 2'd0;
  end

  always_comb begin
    // NOTE: every next-value gets a default first, so no path can infer a latch.
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_id_nxt    = r_id;
    w_len_nxt   = r_len;
    w_data_nxt  = r_data;
    w_cnt_nxt   = r_cnt;
    w_ser_nxt   = r_ser;
    w_grant_nxt = 4'b0000;
    w_ack_nxt   = 4'b0000;
    w_err_nxt   = 1'b0;
    w_busy_nxt  = r_busy;

    case (r_state)
      S_IDLE: begin
        if (clkEn && w_req_hit) begin
          w_grant_nxt = 4'b0001 << w_sel;
          w_id_nxt    = w_sel;
          w_len_nxt   = Len[w_sel*LEN_W +: LEN_W];
          w_data_nxt  = DataIn[w_sel*DATA_W +: DATA_W];
          w_ser_nxt   = 1'b0;
          w_busy_nxt  = 1'b1;
          w_ptr_nxt   = w_hipri ? r_ptr : w_sel + 2'd1;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (clkEn) begin
          w_ser_nxt   = r_id[1];
          w_cnt_nxt   = CNT_W'(1);
          w_state_nxt = S_PORT;
        end
      end
      S_PORT: begin
        if (clkEn) begin
          if (r_cnt != '0) begin
            w_ser_nxt = r_id[0];
            w_cnt_nxt = '0;
          end else begin
            w_ser_nxt   = r_len[LEN_W-1];
            w_cnt_nxt   = CNT_W'(LEN_W - 1);
            w_state_nxt = S_LENF;
          end
        end
      end
      S_LENF: begin
        if (clkEn) begin
          if (r_cnt != '0) begin
            w_ser_nxt = r_len[w_len_idx];
            w_cnt_nxt = r_cnt - CNT_W'(1);
          end else begin
            w_ser_nxt   = r_data[r_len];
            w_cnt_nxt   = CNT_W'(r_len);
            w_state_nxt = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (clkEn) begin
          if (r_cnt != '0) begin
            w_ser_nxt = r_data[w_dat_idx];
            w_cnt_nxt = r_cnt - CNT_W'(1);
          end else begin
            w_ser_nxt   = 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = S_WAIT_DONE;
          end
        end
      end
      S_WAIT_DONE: begin
        // Done is checked on every clock; only the timeout count needs clkEn.
        if (Done) begin
          w_ack_nxt   = 4'b0001 << r_id;
          w_cnt_nxt   = '0;
          w_state_nxt = S_GAP;
        end else if (clkEn) begin
          if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
            w_err_nxt   = 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = S_GAP;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end
      S_GAP: begin
        if (clkEn) begin
          if (r_cnt == CNT_W'(GAP_CYC - 1)) begin
            w_cnt_nxt   = '0;
            w_busy_nxt  = 1'b0;
            w_state_nxt = S_IDLE;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_id    <= '0;
      r_len   <= '0;
      r_data  <= '0;
      r_cnt   <= '0;
      r_ser   <= 1'b1;
      r_grant <= '0;
      r_ack   <= '0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_id    <= w_id_nxt;
      r_len   <= w_len_nxt;
      r_data  <= w_data_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ser   <= w_ser_nxt;
      r_grant <= w_grant_nxt;
      r_ack   <= w_ack_nxt;
      r_err   <= w_err_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  assign SerIn = r_ser;
  assign Grant = r_grant;
  assign Ack   = r_ack;
  assign Err   = r_err;
  assign Busy  = r_busy;

endmodule
